// File: rtl/bw_mult_axil_slave.sv
// AXI4-Lite slave fronting a sequential signed Baugh-Wooley multiplier (OPA, OPB, CTRL/STATUS, RESULT).
// One beat per channel in flight; a product needs N+1 cycles after the accepted START.
module bw_mult_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int N                  = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            mult_done
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int PW = 2 * N;
    localparam int CW = $clog2(N + 1);
    localparam logic [PW-1:0] BW_CORR = (PW'(1) << N) | (PW'(1) << (PW - 1));

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic            aw_rdy_q, aw_rdy_d, bvld_q, bvld_d;
    logic            ar_rdy_q, ar_rdy_d, rvld_q, rvld_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [N-1:0]    opa_q, opa_d, opb_q, opb_d;
    logic [N-1:0]    a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [PW-1:0]   acc_q, acc_d, res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d, ovr_q, ovr_d;

    logic            wr_fire, rd_fire, start_req, ovr_clr, busy, b_bit, last_row;
    logic [1:0]      wr_sel, rd_sel;
    logic [DW-1:0]   wr_old, wr_merge, rd_mux;
    logic [PW-1:0]   row;

    assign wr_fire   = aw_rdy_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire   = ar_rdy_q && S_AXI_ARVALID;
    assign wr_sel    = S_AXI_AWADDR[3:2];
    assign rd_sel    = S_AXI_ARADDR[3:2];
    assign start_req = wr_fire && (wr_sel == 2'd2) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
    assign ovr_clr   = wr_fire && (wr_sel == 2'd2) && S_AXI_WSTRB[0] && S_AXI_WDATA[2];
    assign busy      = (state_q == S_RUN);
    assign last_row  = (cnt_q == CW'(N - 1));

    // Byte-lane merge of the incoming write into the addressed operand register
    always_comb begin
        wr_old   = (wr_sel == 2'd1) ? DW'(opb_q) : DW'(opa_q);
        wr_merge = wr_old;
        for (int b = 0; b < DW / 8; b++) begin
            if (S_AXI_WSTRB[b]) wr_merge[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            2'd0:    rd_mux = DW'(opa_q);
            2'd1:    rd_mux = DW'(opb_q);
            2'd2:    rd_mux = DW'({ovr_q, done_q, busy});
            default: rd_mux = DW'(res_q);
        endcase
    end

    always_comb begin
        aw_rdy_d = !aw_rdy_q && S_AXI_AWVALID && S_AXI_WVALID && !bvld_q;
        ar_rdy_d = !ar_rdy_q && S_AXI_ARVALID && !rvld_q;
        bvld_d   = bvld_q;
        rvld_d   = rvld_q;
        rdata_d  = rdata_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        if (wr_fire) begin
            bvld_d = 1'b1;
            if (wr_sel == 2'd0) opa_d = wr_merge[N-1:0];
            if (wr_sel == 2'd1) opb_d = wr_merge[N-1:0];
        end else if (bvld_q && S_AXI_BREADY) begin
            bvld_d = 1'b0;
        end
        if (rd_fire) begin
            rvld_d  = 1'b1;
            rdata_d = rd_mux;
        end else if (rvld_q && S_AXI_RREADY) begin
            rvld_d = 1'b0;
        end
    end

    // Row cnt of the Baugh-Wooley array: bits where exactly one index is the sign position are inverted
    always_comb begin
        b_bit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) b_bit = b_sh_q[i];
        end
        row = '0;
        for (int j = 0; j < N; j++) begin
            row[j] = (a_sh_q[j] & b_bit) ^ ((j == N - 1) != last_row);
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        if (ovr_clr) ovr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    a_sh_d  = opa_q;
                    b_sh_d  = opb_q;
                    acc_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            default: begin
                if (start_req) ovr_d = 1'b1;
                if (cnt_q == CW'(N)) begin
                    res_d   = acc_q + BW_CORR;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_q + (row << cnt_q);
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= S_IDLE;
            aw_rdy_q <= 1'b0;
            bvld_q   <= 1'b0;
            ar_rdy_q <= 1'b0;
            rvld_q   <= 1'b0;
            rdata_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            aw_rdy_q <= aw_rdy_d;
            bvld_q   <= bvld_d;
            ar_rdy_q <= ar_rdy_d;
            rvld_q   <= rvld_d;
            rdata_q  <= rdata_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign S_AXI_AWREADY = aw_rdy_q;
    assign S_AXI_WREADY  = aw_rdy_q;
    assign S_AXI_BVALID  = bvld_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_rdy_q;
    assign S_AXI_RVALID  = rvld_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign mult_done     = done_q;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, wr_merge};

endmodule

// File: tb/tb_bw_mult_axil_slave.sv
// Scoreboarded bench for bw_mult_axil_slave: bus tasks push expected responses, a negedge monitor checks them.
// Reference model uses signed integer multiplication and edge-numbered status timing.
module tb_bw_mult_axil_slave;
    localparam int N   = 16;
    localparam int TMO = 100;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, mult_done;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;

    bw_mult_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .N(N)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .mult_done(mult_done)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0]  bexp_q[$];
    logic [31:0] rexp_q[$];
    string       rname_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model; edge e means the state right after the e-th rising clock edge
    logic [15:0] m_opa, m_opb;
    logic [31:0] m_res_old, m_res_new;
    bit          m_started, m_ovr;
    int          m_t;

    function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
        int pa = $signed(a);
        int pb = $signed(b);
        return 32'(pa * pb);
    endfunction

    function automatic bit busy_after(input int e);
        return m_started && e >= m_t && e <= m_t + N;
    endfunction

    function automatic bit done_after(input int e);
        return m_started && e >= m_t + N + 1;
    endfunction

    function automatic logic [31:0] res_after(input int e);
        return done_after(e) ? m_res_new : m_res_old;
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [15:0] r = old;
        if (s[0]) r[7:0] = d[7:0];
        if (s[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    function automatic void model_reset();
        m_opa = 0; m_opb = 0; m_res_old = 0; m_res_new = 0;
        m_started = 0; m_ovr = 0; m_t = 0;
    endfunction

    function automatic void model_write(input logic [1:0] sel, input logic [31:0] d, input logic [3:0] s, input int w);
        case (sel)
            2'd0: m_opa = merge16(m_opa, d, s);
            2'd1: m_opb = merge16(m_opb, d, s);
            2'd2: if (s[0]) begin
                if (d[2]) m_ovr = 0;
                if (d[0]) begin
                    if (busy_after(w - 1)) m_ovr = 1;
                    else begin
                        m_res_old = res_after(w - 1);
                        m_res_new = prod(m_opa, m_opb);
                        m_t = w;
                        m_started = 1;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] sel, input int a);
        case (sel)
            2'd0:    return {16'h0, m_opa};
            2'd1:    return {16'h0, m_opb};
            2'd2:    return {29'h0, m_ovr, done_after(a), busy_after(a)};
            default: return res_after(a);
        endcase
    endfunction

    task automatic write_issue(input logic [1:0] sel, input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        @(posedge ACLK); #1;
        AWADDR = {sel, 2'b00}; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
        for (int k = 0; k < TMO; k++) begin
            @(negedge ACLK);
            if (AWREADY && WREADY) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL aw_handshake: no AWREADY/WREADY within %0d cycles", TMO);
        end else begin
            model_write(sel, d, s, cyc + 1);
            bexp_q.push_back(2'b00);
        end
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
    endtask

    task automatic wait_b();
        bit ok = 0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge ACLK);
            if (BVALID && BREADY) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL b_handshake: no BVALID within %0d cycles", TMO);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic read_issue(input logic [1:0] sel, input string nm);
        bit ok = 0;
        @(posedge ACLK); #1;
        ARADDR = {sel, 2'b00}; ARVALID = 1;
        for (int k = 0; k < TMO; k++) begin
            @(negedge ACLK);
            if (ARREADY) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL ar_handshake: no ARREADY within %0d cycles", TMO);
        end else begin
            rexp_q.push_back(model_read(sel, cyc));
            rname_q.push_back(nm);
        end
        @(posedge ACLK); #1;
        ARVALID = 0;
    endtask

    task automatic wait_r();
        bit ok = 0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge ACLK);
            if (RVALID && RREADY) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL r_handshake: no RVALID within %0d cycles", TMO);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic do_write(input logic [1:0] sel, input logic [31:0] d, input logic [3:0] s);
        write_issue(sel, d, s);
        wait_b();
    endtask

    task automatic do_read(input logic [1:0] sel, input string nm);
        read_issue(sel, nm);
        wait_r();
    endtask

    // Monitor: pops the scoreboard whenever a response handshake is about to complete
    always @(negedge ACLK) begin
        if (BVALID && BREADY) begin
            if (bexp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL bresp_unexpected: got BVALID=1, expected no response");
            end else check("bresp", 32'(BRESP), 32'(bexp_q.pop_front()));
        end
        if (RVALID && RREADY) begin
            if (rexp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rdata_unexpected: got RVALID=1 RDATA=0x%08h, expected no response", RDATA);
            end else begin
                check({"rdata ", rname_q.pop_front()}, RDATA, rexp_q.pop_front());
                check("rresp", 32'(RRESP), 32'h0);
            end
        end
    end

    task automatic check_outs_zero(input string nm);
        check({nm, " ctrl_outs"}, 32'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, mult_done}), 32'h0);
        check({nm, " rdata"}, RDATA, 32'h0);
    endtask

    logic [15:0] dir_a[4] = '{16'hFFFF, 16'h8000, 16'h8000, 16'h0000};
    logic [15:0] dir_b[4] = '{16'h0001, 16'h8000, 16'h7FFF, 16'h8000};

    initial begin
        ARESETN = 0; AWADDR = 0; ARADDR = 0; AWPROT = 0; ARPROT = 0;
        AWVALID = 0; WVALID = 0; ARVALID = 0; WDATA = 0; WSTRB = 0;
        BREADY = 1; RREADY = 1;
        model_reset();
        repeat (3) @(posedge ACLK);
        #1; check_outs_zero("reset");
        ARESETN = 1;
        do_read(2'd2, "reset status");
        do_read(2'd3, "reset result");

        // Basic 3 x 5 with status polling across BUSY -> DONE
        do_write(2'd0, 32'd3, 4'hF);
        do_write(2'd1, 32'd5, 4'hF);
        do_write(2'd2, 32'h1, 4'h1);
        for (int i = 0; i < 8; i++) do_read(2'd2, "poll status");
        do_read(2'd3, "3x5 result");

        for (int i = 0; i < 4; i++) begin
            do_write(2'd0, {16'h0, dir_a[i]}, 4'hF);
            do_write(2'd1, {16'h0, dir_b[i]}, 4'hF);
            do_write(2'd2, 32'h1, 4'h1);
            repeat (N + 4) @(posedge ACLK);
            do_read(2'd3, "directed result");
            @(negedge ACLK);
            check("mult_done", 32'(mult_done), 32'(done_after(cyc)));
        end

        // START while busy, operand rewrite while busy, then OVR clear
        do_write(2'd0, 32'd7, 4'hF);
        do_write(2'd1, 32'd9, 4'hF);
        do_write(2'd2, 32'h1, 4'h1);
        do_write(2'd0, 32'h0100, 4'hF);
        do_write(2'd2, 32'h1, 4'h1);
        repeat (N + 4) @(posedge ACLK);
        do_read(2'd3, "result after ovr");
        do_read(2'd2, "status ovr set");
        do_write(2'd2, 32'h4, 4'h1);
        do_read(2'd2, "status ovr cleared");

        // Byte strobes and RESULT write
        do_write(2'd0, 32'h1234, 4'hF);
        do_write(2'd0, 32'hABCD, 4'h1);
        do_read(2'd0, "opa strobe");
        do_write(2'd3, 32'hFFFF_FFFF, 4'hF);
        do_read(2'd3, "result after write");

        // Randomized operands, strobes and timing
        for (int it = 0; it < 25; it++) begin
            int w;
            do_write(2'd0, $urandom, 4'hF);
            do_write(2'd1, $urandom, 4'($urandom_range(0, 15)));
            do_write(2'd2, 32'h1, 4'h1);
            w = $urandom_range(0, 3);
            if (w == 0) do_write(2'd2, 32'h1, 4'h1);
            if (w == 1) do_write(2'd0, $urandom, 4'($urandom_range(0, 15)));
            if (w == 2) do_write(2'd2, 32'h5, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 20)) @(posedge ACLK);
            do_read(2'd2, "rand status");
            do_read(2'd3, "rand result");
            do_read(2'($urandom_range(0, 3)), "rand reg");
            if ($urandom_range(0, 1) == 1) do_write(2'd2, 32'h4, 4'h1);
        end

        // Backpressure on B and R channels
        repeat (N + 4) @(posedge ACLK);
        BREADY = 0; RREADY = 0;
        write_issue(2'd0, 32'h5A5A, 4'hF);
        AWADDR = 4'h4; WDATA = 32'h0000_DEAD; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        repeat (5) begin
            @(negedge ACLK);
            check("stall bvalid", 32'(BVALID), 32'h1);
            check("stall awready", 32'(AWREADY), 32'h0);
        end
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0; BREADY = 1;
        wait_b();
        read_issue(2'd0, "stalled opa");
        repeat (5) begin
            @(negedge ACLK);
            check("stall rvalid", 32'(RVALID), 32'h1);
            if (rexp_q.size() > 0) check("stall rdata", RDATA, rexp_q[0]);
        end
        @(posedge ACLK); #1;
        RREADY = 1;
        wait_r();
        do_read(2'd1, "opb not overwritten");

        // Reset in the middle of a run
        do_write(2'd0, 32'h1357, 4'hF);
        do_write(2'd1, 32'h2468, 4'hF);
        write_issue(2'd2, 32'h1, 4'h1);
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 0;
        #1 check_outs_zero("async reset");
        model_reset();
        bexp_q.delete(); rexp_q.delete(); rname_q.delete();
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1;
        repeat (5) begin
            @(negedge ACLK);
            check("post-reset valids", 32'({BVALID, RVALID}), 32'h0);
        end
        do_read(2'd2, "post-reset status");
        do_read(2'd3, "post-reset result");
        do_read(2'd0, "post-reset opa");

        repeat (3) @(posedge ACLK);
        if (bexp_q.size() != 0 || rexp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_drain: got %0d B / %0d R responses outstanding, expected 0", bexp_q.size(), rexp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
